// File: rtl/cdb_arbiter_if.sv
// Functional-unit result handshake and CDB broadcast bundle for cdb_arbiter.
// master = issue/FU side, slave = arbiter.
interface cdb_arbiter_if #(
    parameter int NUM_REQUESTER     = 4,
    parameter int BW_TAG            = 3,
    parameter int BW_PROCESSOR_DATA = 32
);
    logic [NUM_REQUESTER-1:0]                   i_fu_valid;
    logic [NUM_REQUESTER-1:0]                   o_fu_ready;
    logic [NUM_REQUESTER*BW_TAG-1:0]            i_fu_tag_flatten;
    logic [NUM_REQUESTER*BW_PROCESSOR_DATA-1:0] i_fu_data_flatten;
    logic [NUM_REQUESTER-1:0]                   i_fu_speculation;
    logic                                       i_branch_valid;
    logic                                       i_branch_correct_prediction;
    logic                                       o_cdb_valid;
    logic [BW_TAG-1:0]                          o_cdb_tag;
    logic [BW_PROCESSOR_DATA-1:0]               o_cdb_data;
    logic [NUM_REQUESTER-1:0]                   o_pending;

    modport master (
        output i_fu_valid, i_fu_tag_flatten, i_fu_data_flatten, i_fu_speculation,
               i_branch_valid, i_branch_correct_prediction,
        input  o_fu_ready, o_cdb_valid, o_cdb_tag, o_cdb_data, o_pending
    );

    modport slave (
        input  i_fu_valid, i_fu_tag_flatten, i_fu_data_flatten, i_fu_speculation,
               i_branch_valid, i_branch_correct_prediction,
        output o_fu_ready, o_cdb_valid, o_cdb_tag, o_cdb_data, o_pending
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: one-entry buffer per functional unit, one registered broadcast per cycle.
// CDB_ARBITER_FLUSH_EN enables squashing of speculative buffered results on a mispredict.
module cdb_arbiter #(
    parameter int NUM_REQUESTER     = 4,
    parameter int BW_TAG            = 3,
    parameter int BW_PROCESSOR_DATA = 32
) (
    input logic          clk,
    input logic          rst_n,
    cdb_arbiter_if.slave bus
);
    localparam int BW_PTR = (NUM_REQUESTER > 1) ? $clog2(NUM_REQUESTER) : 1;

    logic [NUM_REQUESTER-1:0]                        hold_valid;
    logic [NUM_REQUESTER-1:0][BW_TAG-1:0]            hold_tag;
    logic [NUM_REQUESTER-1:0][BW_PROCESSOR_DATA-1:0] hold_data;
    logic [NUM_REQUESTER-1:0]                        eligible, grant, flush, load, ready;
    logic [BW_PTR-1:0]                               ptr, winner;
    logic                                            any_grant;
    logic                                            cdb_valid;
    logic [BW_TAG-1:0]                               cdb_tag;
    logic [BW_PROCESSOR_DATA-1:0]                    cdb_data;

`ifdef CDB_ARBITER_FLUSH_EN
    logic [NUM_REQUESTER-1:0] hold_spec;
    logic mispredict, correct;
    assign mispredict = bus.i_branch_valid && !bus.i_branch_correct_prediction;
    assign correct    = bus.i_branch_valid &&  bus.i_branch_correct_prediction;
    assign flush      = mispredict ? (hold_valid & hold_spec) : '0;
`else
    assign flush = '0;
`endif

    assign eligible = hold_valid & ~flush;
    assign ready    = ~hold_valid | grant;

    // First eligible index at or after ptr, wrapping.
    always_comb begin
        int idx;
        grant     = '0;
        any_grant = 1'b0;
        winner    = '0;
        idx       = 0;
        for (int k = 0; k < NUM_REQUESTER; k++) begin
            idx = (int'(ptr) + k) % NUM_REQUESTER;
            if (!any_grant && eligible[idx]) begin
                any_grant = 1'b1;
                winner    = BW_PTR'(idx);
            end
        end
        if (any_grant) grant[winner] = 1'b1;
    end

    for (genvar i = 0; i < NUM_REQUESTER; i++) begin : g_lane
        logic [BW_TAG-1:0] in_tag;
        assign in_tag = bus.i_fu_tag_flatten[i*BW_TAG +: BW_TAG];

        // Tag 0 handshakes complete but never occupy the buffer.
`ifdef CDB_ARBITER_FLUSH_EN
        assign load[i] = bus.i_fu_valid[i] && ready[i] && (in_tag != '0) &&
                         !(mispredict && bus.i_fu_speculation[i]);
`else
        assign load[i] = bus.i_fu_valid[i] && ready[i] && (in_tag != '0);
`endif

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                hold_valid[i] <= 1'b0;
                hold_tag[i]   <= '0;
                hold_data[i]  <= '0;
            end else if (load[i]) begin
                hold_valid[i] <= 1'b1;
                hold_tag[i]   <= in_tag;
                hold_data[i]  <= bus.i_fu_data_flatten[i*BW_PROCESSOR_DATA +: BW_PROCESSOR_DATA];
            end else if (grant[i] || flush[i]) begin
                hold_valid[i] <= 1'b0;
            end
        end

`ifdef CDB_ARBITER_FLUSH_EN
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                hold_spec[i] <= 1'b0;
            else if (load[i])
                hold_spec[i] <= bus.i_fu_speculation[i] && !correct;
            else if (correct || grant[i] || flush[i])
                hold_spec[i] <= 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_data  <= '0;
            ptr       <= '0;
        end else begin
            cdb_valid <= any_grant;
            if (any_grant) begin
                cdb_tag  <= hold_tag[winner];
                cdb_data <= hold_data[winner];
                ptr      <= BW_PTR'((int'(winner) + 1) % NUM_REQUESTER);
            end
        end
    end

    assign bus.o_fu_ready  = ready;
    assign bus.o_cdb_valid = cdb_valid;
    assign bus.o_cdb_tag   = cdb_tag;
    assign bus.o_cdb_data  = cdb_data;
    assign bus.o_pending   = hold_valid;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter (4 units, 3-bit tags, 32-bit data).
module tb_cdb_arbiter;
    localparam int N  = 4;
    localparam int TW = 3;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    cdb_arbiter_if #(.NUM_REQUESTER(N), .BW_TAG(TW), .BW_PROCESSOR_DATA(DW)) bus ();

    cdb_arbiter #(.NUM_REQUESTER(N), .BW_TAG(TW), .BW_PROCESSOR_DATA(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.i_fu_valid                  = '0;
        bus.i_fu_speculation            = '0;
        bus.i_branch_valid              = 1'b0;
        bus.i_branch_correct_prediction = 1'b0;
    endtask

    task automatic test_reset;
        idle_inputs();
        bus.i_fu_tag_flatten  = '0;
        bus.i_fu_data_flatten = '0;
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if (bus.o_fu_ready !== 4'b1111) begin errors++; $display("FAIL reset_ready got=%b exp=1111", bus.o_fu_ready); end
        checks++; if (bus.o_cdb_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.o_cdb_valid); end
        checks++; if (bus.o_cdb_tag !== 3'd0 || bus.o_cdb_data !== 32'd0) begin errors++; $display("FAIL reset_cdb got=%0d/%h exp=0/0", bus.o_cdb_tag, bus.o_cdb_data); end
        checks++; if (bus.o_pending !== 4'b0000) begin errors++; $display("FAIL reset_pending got=%b exp=0000", bus.o_pending); end
        rst_n = 1'b1;
    endtask

    task automatic test_single;
        bus.i_fu_valid[2]                 = 1'b1;
        bus.i_fu_tag_flatten[2*TW +: TW]  = 3'd5;
        bus.i_fu_data_flatten[2*DW +: DW] = 32'h1234;
        tick();
        bus.i_fu_valid = '0;
        checks++; if (bus.o_pending !== 4'b0100 || bus.o_cdb_valid !== 1'b0) begin errors++; $display("FAIL single_edge1 pending=%b valid=%b exp=0100/0", bus.o_pending, bus.o_cdb_valid); end
        tick();
        checks++; if (bus.o_cdb_valid !== 1'b1 || bus.o_cdb_tag !== 3'd5 || bus.o_cdb_data !== 32'h1234) begin errors++; $display("FAIL single_bcast got=%b/%0d/%h exp=1/5/1234", bus.o_cdb_valid, bus.o_cdb_tag, bus.o_cdb_data); end
        checks++; if (bus.o_pending !== 4'b0000) begin errors++; $display("FAIL single_drain pending=%b exp=0000", bus.o_pending); end
        tick();
        checks++; if (bus.o_cdb_valid !== 1'b0 || bus.o_cdb_tag !== 3'd5) begin errors++; $display("FAIL single_oneshot got=%b/%0d exp=0/5", bus.o_cdb_valid, bus.o_cdb_tag); end
    endtask

    task automatic test_tag_zero;
        bus.i_fu_valid[1]                = 1'b1;
        bus.i_fu_tag_flatten[1*TW +: TW] = 3'd0;
        #1;
        checks++; if (bus.o_fu_ready[1] !== 1'b1) begin errors++; $display("FAIL tag0_ready got=%b exp=1", bus.o_fu_ready[1]); end
        tick();
        bus.i_fu_valid = '0;
        checks++; if (bus.o_pending !== 4'b0000) begin errors++; $display("FAIL tag0_pending got=%b exp=0000", bus.o_pending); end
        tick();
        checks++; if (bus.o_cdb_valid !== 1'b0) begin errors++; $display("FAIL tag0_bcast got=%b exp=0", bus.o_cdb_valid); end
    endtask

    // ptr is 3 here, left by the unit-2 grant in test_single.
    task automatic test_wrap;
        bus.i_fu_valid                    = 4'b1001;
        bus.i_fu_tag_flatten[0*TW +: TW]  = 3'd1;
        bus.i_fu_tag_flatten[3*TW +: TW]  = 3'd6;
        bus.i_fu_data_flatten[0*DW +: DW] = 32'h11;
        bus.i_fu_data_flatten[3*DW +: DW] = 32'h66;
        tick();
        bus.i_fu_valid = '0;
        checks++; if (bus.o_pending !== 4'b1001) begin errors++; $display("FAIL wrap_load pending=%b exp=1001", bus.o_pending); end
        tick();
        checks++; if (bus.o_cdb_valid !== 1'b1 || bus.o_cdb_tag !== 3'd6 || bus.o_cdb_data !== 32'h66) begin errors++; $display("FAIL wrap_first got=%b/%0d/%h exp=1/6/66", bus.o_cdb_valid, bus.o_cdb_tag, bus.o_cdb_data); end
        checks++; if (bus.o_pending !== 4'b0001) begin errors++; $display("FAIL wrap_pending got=%b exp=0001", bus.o_pending); end
        tick();
        checks++; if (bus.o_cdb_valid !== 1'b1 || bus.o_cdb_tag !== 3'd1 || bus.o_cdb_data !== 32'h11) begin errors++; $display("FAIL wrap_second got=%b/%0d/%h exp=1/1/11", bus.o_cdb_valid, bus.o_cdb_tag, bus.o_cdb_data); end
        // ptr should now be 1: of units 0 and 2, unit 2 wins first.
        bus.i_fu_valid                   = 4'b0101;
        bus.i_fu_tag_flatten[0*TW +: TW] = 3'd2;
        bus.i_fu_tag_flatten[2*TW +: TW] = 3'd3;
        tick();
        bus.i_fu_valid = '0;
        tick();
        checks++; if (bus.o_cdb_tag !== 3'd3) begin errors++; $display("FAIL wrap_ptr1_first got=%0d exp=3", bus.o_cdb_tag); end
        tick();
        checks++; if (bus.o_cdb_tag !== 3'd2) begin errors++; $display("FAIL wrap_ptr1_second got=%0d exp=2", bus.o_cdb_tag); end
        tick();
        checks++; if (bus.o_cdb_valid !== 1'b0) begin errors++; $display("FAIL wrap_idle got=%b exp=0", bus.o_cdb_valid); end
    endtask

    task automatic test_back_to_back;
        logic [3:0] exp_ready;
        logic [2:0] exp_tag;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) begin
            bus.i_fu_tag_flatten[i*TW +: TW]  = TW'(i + 1);
            bus.i_fu_data_flatten[i*DW +: DW] = 32'(100 + i);
        end
        bus.i_fu_valid = 4'b1111;
        for (int n = 1; n <= 12; n++) begin
            tick();
            exp_ready = 4'b0001 << ((n - 1) % 4);
            checks++; if (bus.o_fu_ready !== exp_ready) begin errors++; $display("FAIL b2b_ready cyc=%0d got=%b exp=%b", n, bus.o_fu_ready, exp_ready); end
            if (n >= 2) begin
                exp_tag = 3'(((n - 2) % 4) + 1);
                checks++;
                if (bus.o_cdb_valid !== 1'b1 || bus.o_cdb_tag !== exp_tag || bus.o_cdb_data !== 32'(99 + exp_tag)) begin
                    errors++;
                    $display("FAIL b2b_bcast cyc=%0d got=%b/%0d/%0d exp=1/%0d/%0d", n, bus.o_cdb_valid, bus.o_cdb_tag, bus.o_cdb_data, exp_tag, 99 + exp_tag);
                end
            end
        end
        bus.i_fu_valid = '0;
        repeat (4) tick();
        checks++; if (bus.o_pending !== 4'b0000 || bus.o_cdb_valid !== 1'b1) begin errors++; $display("FAIL b2b_drain pending=%b valid=%b exp=0000/1", bus.o_pending, bus.o_cdb_valid); end
        tick();
        checks++; if (bus.o_cdb_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle got=%b exp=0", bus.o_cdb_valid); end
    endtask

    task automatic test_async_reset;
        bus.i_fu_valid                   = 4'b0011;
        bus.i_fu_tag_flatten[0*TW +: TW] = 3'd1;
        bus.i_fu_tag_flatten[1*TW +: TW] = 3'd2;
        tick();
        bus.i_fu_valid = '0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.o_pending !== 4'b0000 || bus.o_cdb_valid !== 1'b0 || bus.o_cdb_tag !== 3'd0) begin errors++; $display("FAIL async_reset pending=%b valid=%b tag=%0d exp=0000/0/0", bus.o_pending, bus.o_cdb_valid, bus.o_cdb_tag); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

`ifdef CDB_ARBITER_FLUSH_EN
    task automatic test_flush;
        bus.i_fu_valid                   = 4'b0110;
        bus.i_fu_speculation             = 4'b0010;
        bus.i_fu_tag_flatten[1*TW +: TW] = 3'd2;
        bus.i_fu_tag_flatten[2*TW +: TW] = 3'd3;
        tick();
        idle_inputs();
        bus.i_branch_valid = 1'b1;
        tick();
        bus.i_branch_valid = 1'b0;
        checks++; if (bus.o_cdb_valid !== 1'b1 || bus.o_cdb_tag !== 3'd3) begin errors++; $display("FAIL flush_survivor got=%b/%0d exp=1/3", bus.o_cdb_valid, bus.o_cdb_tag); end
        checks++; if (bus.o_pending !== 4'b0000) begin errors++; $display("FAIL flush_pending got=%b exp=0000", bus.o_pending); end
        tick();
        checks++; if (bus.o_cdb_valid !== 1'b0) begin errors++; $display("FAIL flush_idle got=%b exp=0", bus.o_cdb_valid); end
        // Speculative load in the mispredict cycle is dropped.
        bus.i_fu_valid[3] = 1'b1; bus.i_fu_speculation[3] = 1'b1;
        bus.i_fu_tag_flatten[3*TW +: TW] = 3'd5;
        bus.i_branch_valid = 1'b1;
        tick();
        idle_inputs();
        checks++; if (bus.o_pending !== 4'b0000) begin errors++; $display("FAIL flush_sameload got=%b exp=0000", bus.o_pending); end
    endtask

    task automatic test_branch;
        bus.i_fu_valid[1] = 1'b1; bus.i_fu_speculation[1] = 1'b1;
        bus.i_fu_tag_flatten[1*TW +: TW] = 3'd4;
        bus.i_branch_valid = 1'b1; bus.i_branch_correct_prediction = 1'b1;
        tick();
        idle_inputs();
        bus.i_branch_valid = 1'b1;
        tick();
        idle_inputs();
        checks++; if (bus.o_cdb_valid !== 1'b1 || bus.o_cdb_tag !== 3'd4) begin errors++; $display("FAIL resolved_kept got=%b/%0d exp=1/4", bus.o_cdb_valid, bus.o_cdb_tag); end
    endtask
`else
    task automatic test_branch;
        bus.i_fu_valid[1] = 1'b1; bus.i_fu_speculation[1] = 1'b1;
        bus.i_fu_tag_flatten[1*TW +: TW] = 3'd7;
        tick();
        idle_inputs();
        bus.i_branch_valid = 1'b1;
        tick();
        idle_inputs();
        checks++; if (bus.o_cdb_valid !== 1'b1 || bus.o_cdb_tag !== 3'd7) begin errors++; $display("FAIL branch_ignored got=%b/%0d exp=1/7", bus.o_cdb_valid, bus.o_cdb_tag); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_tag_zero();
        test_wrap();
        test_back_to_back();
        test_async_reset();
`ifdef CDB_ARBITER_FLUSH_EN
        test_flush();
`endif
        test_branch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
